// File: rtl/serial_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_seq_if
//  Brief    : Handshake and data bundle for the nibble-serial adder. The
//             master modport is the requester/consumer side; the slave
//             modport is the adder itself.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_add_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        busy;

    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, busy
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_seq
//  Brief    : 16-bit adder built from one 4-bit carry-lookahead slice that is
//             reused over four cycles, one nibble per cycle, LSB first.
//             Optional subtract (A-B) enabled by macro SERIAL_ADD_SEQ_SUB_EN.
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_seq (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_add_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_carry;
    logic [15:0] r_sum;
    logic        r_cout;
    logic        r_ovf;
    logic        r_zero;

    logic        w_accept;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_busy;
    logic [15:0] w_b_eff;
    logic        w_cin_eff;

    // Operand conditioning at acceptance: subtract is A + ~B + 1.
`ifdef SERIAL_ADD_SEQ_SUB_EN
    assign w_b_eff   = bus.op_sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.op_sub ? 1'b1   : bus.cin;
`else
    wire w_unused_op_sub = bus.op_sub;
    assign w_b_eff   = bus.b;
    assign w_cin_eff = bus.cin;
`endif

    // Shared 4-bit carry-lookahead slice, fed by the nibble selected by r_idx
    logic [3:0] w_sa;
    logic [3:0] w_sb;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic [3:0] w_s;

    assign w_sa = r_a[{r_idx, 2'b00} +: 4];
    assign w_sb = r_b[{r_idx, 2'b00} +: 4];
    assign w_g  = w_sa & w_sb;
    assign w_p  = w_sa ^ w_sb;

    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_s    = w_p ^ w_c[3:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch and nibble-serial accumulation of the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_carry <= 1'b0;
            r_sum   <= 16'h0000;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= 2'd0;
        end else if (r_state == S_RUN) begin
            r_sum[{r_idx, 2'b00} +: 4] <= w_s;
            r_carry                    <= w_c[4];
            r_idx                      <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                // Flags come from the top nibble: carry into bit 15 is the
                // slice's internal carry into its bit 3.
                r_cout <= w_c[4];
                r_ovf  <= w_c[3] ^ w_c[4];
                r_zero <= ({w_s, r_sum[11:0]} == 16'h0000);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule
`default_nettype wire
